// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter.
package wb_arbiter_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREG  = 32;
  localparam int unsigned REG_W = 5;

  // One buffered long-latency result headed for the register file
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous in-order FIFO of writeback requests; no write-to-read bypass.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  wb_req_t                  din_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output wb_req_t                  head_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  wb_req_t        mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Next pointer/occupancy; pointers wrap naturally since DEPTH is a power of 2
  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results win, LL results queue in a FIFO, and a
// scoreboard tracks registers with LL writes still in flight.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned LL_DEPTH   = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  input  logic [REG_W-1:0] alu_rd,
  input  logic [XLEN-1:0]  alu_data,
  input  logic             ll_valid,
  output logic             ll_ready,
  input  logic [REG_W-1:0] ll_rd,
  input  logic [XLEN-1:0]  ll_data,
  input  logic             issue_valid,
  input  logic [REG_W-1:0] issue_rd,
  output logic             rf_we,
  output logic [REG_W-1:0] rf_rd,
  output logic [XLEN-1:0]  rf_wdata,
  output logic [NREG-1:0]  busy_mask,
  output logic             stall_alu
);

  localparam int unsigned FCW = $clog2(LL_DEPTH) + 1;
  localparam int unsigned SW  = $clog2(STARVE_MAX + 1);

  logic            fifo_full, fifo_empty, fifo_push, pop;
  logic [FCW-1:0]  fifo_count;
  wb_req_t         fifo_din, head;
  logic            alu_win, empty_next;
  logic [SW-1:0]   starve_q, starve_d;
  logic            stall_alu_q, stall_alu_d;
  logic [NREG-1:0] busy_q, busy_d;

  assign ll_ready  = !fifo_full && !rst;
  assign fifo_push = ll_valid && ll_ready;
  assign fifo_din  = '{rd: ll_rd, data: ll_data};
  assign alu_win   = alu_valid && (alu_rd != '0);
  assign busy_mask = busy_q;
  assign stall_alu = stall_alu_q;

  wb_fifo #(.DEPTH(LL_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .din_i   (fifo_din),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (head)
  );

  // Write select, starvation tracking and scoreboard next state
  always_comb begin
    rf_we       = 1'b0;
    rf_rd       = '0;
    rf_wdata    = '0;
    pop         = 1'b0;
    starve_d    = starve_q;
    stall_alu_d = stall_alu_q;
    busy_d      = busy_q;

    if (!rst) begin
      if (alu_win) begin
        rf_we    = 1'b1;
        rf_rd    = alu_rd;
        rf_wdata = alu_data;
      end else if (!fifo_empty) begin
        pop      = 1'b1;
        rf_we    = (head.rd != '0);
        rf_rd    = head.rd;
        rf_wdata = head.data;
      end
    end

    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (alu_win && (starve_q != SW'(STARVE_MAX))) begin
      starve_d = starve_q + SW'(1);
    end

    empty_next = ((fifo_count == '0) && !fifo_push) ||
                 ((fifo_count == FCW'(1)) && pop && !fifo_push);
    if (empty_next) begin
      stall_alu_d = 1'b0;
    end else if (starve_d == SW'(STARVE_MAX)) begin
      stall_alu_d = 1'b1;
    end

    // Clear first so a same-cycle reissue of the same register keeps it busy
    if (pop && (head.rd != '0)) busy_d[head.rd] = 1'b0;
    if (issue_valid && (issue_rd != '0)) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q    <= '0;
      stall_alu_q <= 1'b0;
      busy_q      <= '0;
    end else begin
      starve_q    <= starve_d;
      stall_alu_q <= stall_alu_d;
      busy_q      <= busy_d;
    end
  end

  // Upstream must hold off ALU results while stalled
  assert property (@(posedge clk) disable iff (rst) !(stall_alu_q && alu_valid));

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter.
module tb_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [31:0] busy_mask;
  logic        stall_alu;

  int total = 0;
  int bad   = 0;

  wb_arbiter #(.LL_DEPTH(2), .STARVE_MAX(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .ll_valid    (ll_valid),
    .ll_ready    (ll_ready),
    .ll_rd       (ll_rd),
    .ll_data     (ll_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rf_we       (rf_we),
    .rf_rd       (rf_rd),
    .rf_wdata    (rf_wdata),
    .busy_mask   (busy_mask),
    .stall_alu   (stall_alu)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ll_valid = 1'b0; ll_rd = '0; ll_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick(); tick();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1; ll_valid = 1'b1; ll_rd = 5'd2;
    #3;
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%0h exp=0", rf_we); end
    total++; if (ll_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0h exp=0", ll_ready); end
    tick();
    rst = 1'b0;
    idle();
    #3;
    total++; if (busy_mask !== 32'h0) begin bad++; $display("FAIL rst_busy got=%0h exp=0", busy_mask); end
    total++; if (stall_alu !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0h exp=0", stall_alu); end
    total++; if (ll_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after got=%0h exp=1", ll_ready); end
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rst_empty_we got=%0h exp=0", rf_we); end
    tick();
  endtask

  task automatic test_alu();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #3;
    total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL alu_we got=%0h exp=1", rf_we); end
    total++; if (rf_rd !== 5'd5) begin bad++; $display("FAIL alu_rd got=%0h exp=5", rf_rd); end
    total++; if (rf_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL alu_data got=%0h exp=deadbeef", rf_wdata); end
    tick();
    alu_rd = 5'd0;
    #3;
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL alu_x0_we got=%0h exp=0", rf_we); end
    total++; if (rf_wdata !== 32'h0) begin bad++; $display("FAIL alu_x0_data got=%0h exp=0", rf_wdata); end
    tick();
    idle();
  endtask

  task automatic test_ll();
    ll_valid = 1'b1; ll_rd = 5'd7; ll_data = 32'h1234;
    #3;
    total++; if (ll_ready !== 1'b1) begin bad++; $display("FAIL ll_ready got=%0h exp=1", ll_ready); end
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL ll_nobypass got=%0h exp=0", rf_we); end
    tick();
    idle();
    #3;
    total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL ll_we got=%0h exp=1", rf_we); end
    total++; if (rf_rd !== 5'd7) begin bad++; $display("FAIL ll_rd got=%0h exp=7", rf_rd); end
    total++; if (rf_wdata !== 32'h1234) begin bad++; $display("FAIL ll_data got=%0h exp=1234", rf_wdata); end
    tick();
    #3;
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL ll_empty got=%0h exp=0", rf_we); end
    tick();
  endtask

  task automatic test_collision();
    ll_valid = 1'b1; ll_rd = 5'd9; ll_data = 32'h99;
    tick();
    idle();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    #3;
    total++; if (rf_rd !== 5'd3 || rf_we !== 1'b1) begin bad++; $display("FAIL col_alu got=%0h/%0h exp=1/3", rf_we, rf_rd); end
    total++; if (rf_wdata !== 32'h33) begin bad++; $display("FAIL col_alu_data got=%0h exp=33", rf_wdata); end
    tick();
    idle();
    #3;
    total++; if (rf_rd !== 5'd9 || rf_we !== 1'b1) begin bad++; $display("FAIL col_ll got=%0h/%0h exp=1/9", rf_we, rf_rd); end
    total++; if (rf_wdata !== 32'h99) begin bad++; $display("FAIL col_ll_data got=%0h exp=99", rf_wdata); end
    tick();
    // An ALU result to x0 must not block the head
    ll_valid = 1'b1; ll_rd = 5'd11; ll_data = 32'hB1;
    tick();
    idle();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFF;
    #3;
    total++; if (rf_rd !== 5'd11 || rf_we !== 1'b1) begin bad++; $display("FAIL col_x0 got=%0h/%0h exp=1/b", rf_we, rf_rd); end
    total++; if (rf_wdata !== 32'hB1) begin bad++; $display("FAIL col_x0_data got=%0h exp=b1", rf_wdata); end
    tick();
    idle();
    #3;
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL col_drained got=%0h exp=0", rf_we); end
    tick();
  endtask

  task automatic test_back_to_back();
    ll_valid = 1'b1; ll_rd = 5'd0; ll_data = 32'h40;
    tick();
    ll_rd = 5'd5; ll_data = 32'h50;
    #3;
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL b2b_x0_we got=%0h exp=0", rf_we); end
    total++; if (ll_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%0h exp=1", ll_ready); end
    tick();
    ll_rd = 5'd6; ll_data = 32'h60;
    #3;
    total++; if (rf_rd !== 5'd5 || rf_wdata !== 32'h50) begin bad++; $display("FAIL b2b_first got=%0h/%0h exp=5/50", rf_rd, rf_wdata); end
    tick();
    idle();
    #3;
    total++; if (rf_rd !== 5'd6 || rf_wdata !== 32'h60 || rf_we !== 1'b1) begin bad++; $display("FAIL b2b_second got=%0h/%0h exp=6/60", rf_rd, rf_wdata); end
    tick();
    #3;
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%0h exp=0", rf_we); end
    tick();
  endtask

  task automatic test_backpressure();
    // cycle 0: FIFO empty, ALU write does not count as blocking
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h100;
    ll_valid = 1'b1; ll_rd = 5'd12; ll_data = 32'hA;
    tick();
    // cycle 1: blocked #1, second push
    alu_rd = 5'd2; ll_rd = 5'd13; ll_data = 32'hB;
    tick();
    // cycle 2: blocked #2, FIFO full
    alu_rd = 5'd3; ll_rd = 5'd14; ll_data = 32'hC;
    #3;
    total++; if (ll_ready !== 1'b0) begin bad++; $display("FAIL bp_full got=%0h exp=0", ll_ready); end
    total++; if (rf_rd !== 5'd3) begin bad++; $display("FAIL bp_alu_wins got=%0h exp=3", rf_rd); end
    tick();
    alu_rd = 5'd4;
    tick();
    // cycle 4: blocked #4
    alu_rd = 5'd8;
    #3;
    total++; if (stall_alu !== 1'b0) begin bad++; $display("FAIL bp_stall_early got=%0h exp=0", stall_alu); end
    tick();
    idle();
    #3;
    total++; if (stall_alu !== 1'b1) begin bad++; $display("FAIL bp_stall got=%0h exp=1", stall_alu); end
    total++; if (ll_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_stall got=%0h exp=0", ll_ready); end
    total++; if (rf_rd !== 5'd12 || rf_wdata !== 32'hA || rf_we !== 1'b1) begin bad++; $display("FAIL bp_head got=%0h/%0h exp=c/a", rf_rd, rf_wdata); end
    tick();
    #3;
    total++; if (stall_alu !== 1'b1) begin bad++; $display("FAIL bp_stall_hold got=%0h exp=1", stall_alu); end
    total++; if (rf_rd !== 5'd13 || rf_wdata !== 32'hB || rf_we !== 1'b1) begin bad++; $display("FAIL bp_next got=%0h/%0h exp=d/b", rf_rd, rf_wdata); end
    tick();
    #3;
    total++; if (stall_alu !== 1'b0) begin bad++; $display("FAIL bp_stall_clr got=%0h exp=0", stall_alu); end
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL bp_empty got=%0h exp=0", rf_we); end
    tick();
  endtask

  task automatic test_scoreboard();
    issue_valid = 1'b1; issue_rd = 5'd10;
    #3;
    total++; if (busy_mask !== 32'h0) begin bad++; $display("FAIL sb_not_yet got=%0h exp=0", busy_mask); end
    tick();
    idle();
    ll_valid = 1'b1; ll_rd = 5'd10; ll_data = 32'hA10;
    #3;
    total++; if (busy_mask !== 32'h400) begin bad++; $display("FAIL sb_set got=%0h exp=400", busy_mask); end
    tick();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd0;
    #3;
    total++; if (rf_rd !== 5'd10 || rf_we !== 1'b1) begin bad++; $display("FAIL sb_wb got=%0h/%0h exp=1/a", rf_we, rf_rd); end
    tick();
    idle();
    #3;
    total++; if (busy_mask !== 32'h0) begin bad++; $display("FAIL sb_clear got=%0h exp=0", busy_mask); end
    issue_valid = 1'b1; issue_rd = 5'd10;
    tick();
    idle();
    ll_valid = 1'b1; ll_rd = 5'd10; ll_data = 32'hA11;
    tick();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd10;
    #3;
    total++; if (rf_rd !== 5'd10 || rf_we !== 1'b1) begin bad++; $display("FAIL sb_wb2 got=%0h/%0h exp=1/a", rf_we, rf_rd); end
    tick();
    idle();
    #3;
    total++; if (busy_mask !== 32'h400) begin bad++; $display("FAIL sb_set_wins got=%0h exp=400", busy_mask); end
    tick();
  endtask

  task automatic test_reset_mid();
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    ll_valid = 1'b1; ll_rd = 5'd20; ll_data = 32'h20;
    tick();
    alu_rd = 5'd2; ll_rd = 5'd21; ll_data = 32'h21;
    tick();
    idle();
    rst = 1'b1;
    #3;
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rm_we got=%0h exp=0", rf_we); end
    total++; if (ll_ready !== 1'b0) begin bad++; $display("FAIL rm_ready got=%0h exp=0", ll_ready); end
    tick();
    rst = 1'b0;
    #3;
    total++; if (busy_mask !== 32'h0) begin bad++; $display("FAIL rm_busy got=%0h exp=0", busy_mask); end
    total++; if (stall_alu !== 1'b0) begin bad++; $display("FAIL rm_stall got=%0h exp=0", stall_alu); end
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rm_fifo_empty got=%0h exp=0", rf_we); end
    total++; if (ll_ready !== 1'b1) begin bad++; $display("FAIL rm_ready_after got=%0h exp=1", ll_ready); end
    tick();
    #3;
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rm_still_empty got=%0h exp=0", rf_we); end
    tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_ll();
    test_collision();
    test_back_to_back();
    test_backpressure();
    test_scoreboard();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
